nor_flash_responder: RTL and testbench
======================================

Name: nor_flash_responder

Overview:
- Synthesizable responder for the parallel NOR flash command interface: the device side of the CE/WE/OE/ADDR/DATA bus that our flash controllers drive.
- Decodes Intel/StrataFlash-style commands and emulates lock bits, status register, ID space, erase and program busy timing, plus a small modeled array window.
- Used as a loopback target in benches and on-board, so controller state machines can be checked without real flash.

Parameters:
- ACCESS_CYCLES, 3: CLK cycles of CE=0 and OE=0 before DATA is driven.
- ERASE_CYCLES, 1000: busy duration of a block erase; must be >= 2**ARRAY_AW.
- PROG_CYCLES, 20: busy duration of a word program.
- ARRAY_AW, 8: address width of the modeled word window (256 words).
- WIN_BLOCK, 6'h3F: block (ADDR[21:16]) holding the modeled window.
- DEVICE_ID, 16'h0018: value returned at ID offset 1.

Ports:
- CLK input 1: clock; all bus pins sampled here.
- RESET input 1: asynchronous, active-low reset.
- CE input 1: chip enable, active low.
- WE input 1: write enable, active low.
- OE input 1: output enable, active low.
- ADDR input 24: word address.
- DATA inout 16: bidirectional data, high-Z unless reading.
- BUSY output 1: erase or program in progress.
- STATUS output 8: live status register.
- ERR_FLAGS output 4: sticky bus-timing violations (see Optional Feature).

Behaviour:
- Reset (RESET=0, async): all 64 lock bits = 1 (locked); STATUS=8'h80; mode=READ_ARRAY; cmd FSM=IDLE; BUSY=0; counters 0; ERR_FLAGS=0; DATA high-Z. Array contents not reset.
- Write strobe: previous cycle CE=0 and WE=0, current cycle WE=1 or CE=1. ADDR/DATA are taken from the last low cycle via registers. One command per strobe.
- Read drive: enabled when CE=0, OE=0, WE=1 and the OE-low counter >= ACCESS_CYCLES. The counter clears when CE or OE is high. Drive value is registered from the current mode/ADDR. WE=0 forces high-Z.
- Read modes:
  - READ_ARRAY: window word if ADDR[21:16]==WIN_BLOCK, else 16'hFFFF.
  - READ_ID: ADDR[7:0]=0 gives 16'h0089; 1 gives DEVICE_ID; 2 gives {15'b0, lock[ADDR[21:16]]}; any other offset gives 0.
  - READ_STATUS: {8'h00, STATUS}.
- Command FSM states: IDLE, WAIT_LOCK2, WAIT_ERASE2, WAIT_PROG_DATA, ERASING, PROGRAMMING.
  - IDLE, command FF: mode=READ_ARRAY.
  - IDLE, 90: mode=READ_ID.
  - IDLE, 70: mode=READ_STATUS.
  - IDLE, 50: clear STATUS[5:3] and STATUS[1].
  - IDLE, 60: go to WAIT_LOCK2.
  - IDLE, 20: go to WAIT_ERASE2.
  - IDLE, 40 or 10: go to WAIT_PROG_DATA.
  - IDLE, any other value: ignored.
  - WAIT_LOCK2: D0 clears the lock bit of the strobed block; 01 sets it. Either takes effect immediately, mode=READ_STATUS. Any other value sets STATUS[5:4]=2'b11. Always returns to IDLE.
  - WAIT_ERASE2: D0 on an unlocked block enters ERASING (BUSY=1, STATUS[7]=0, wipe index 0, write FFFF one window word per cycle if block==WIN_BLOCK). D0 on a locked block sets STATUS[5]=1 and STATUS[1]=1 and returns to IDLE. Any other value sets STATUS[5:4]=2'b11 and returns to IDLE. mode=READ_STATUS in all cases.
  - WAIT_PROG_DATA: if the block is locked, set STATUS[4]=1 and STATUS[1]=1. Otherwise enter PROGRAMMING and AND the data into the window word (NOR semantics: bits only 1 to 0). mode=READ_STATUS.
  - ERASING/PROGRAMMING: count to ERASE_CYCLES/PROG_CYCLES, then BUSY=0, STATUS[7]=1, return to IDLE. Write strobes during busy are ignored. Reads during busy return status regardless of mode.
- Status bits not listed are 0. STATUS[3] (Vpp) is always 0.
- Reset mid-erase aborts it immediately; partially wiped words stay as wiped.
- Counters saturate, never wrap; the wipe index stops at 2**ARRAY_AW-1.

Optional Feature:
- Macro: NOR_RESP_TIMING_CHECK_EN.
- When defined, ERR_FLAGS is set sticky, cleared only by reset:
  - bit0: WE and OE low together with CE=0.
  - bit1: WE low pulse shorter than 2 cycles.
  - bit2: WE strobe during BUSY.
  - bit3: CE released while a read counter is below ACCESS_CYCLES.
- When undefined, ERR_FLAGS is tied to 4'h0 and no checking logic is built.

Test Plan:
- After reset, write 90 @3F0000, then read @3F0002 for 4 cycles: DATA=0001 (locked). Read @3F0000: DATA=0089.
- Write 60 then D0 @3F0000, then 90, read @3F0002: DATA=0000. Then 70 and read: DATA=0080.
- Erase (20, D0) on locked block @020000: STATUS=8'hA2, BUSY never asserts. Write 50: STATUS=8'h80.
- Unlock 3F, program 40 / 1234 @3F0005, erase 20/D0 @3F0000: BUSY high for ERASE_CYCLES, STATUS[7]=0 during busy. After completion, FF then read @3F0005: DATA=FFFF.
- Program 1234 then 00FF @3F0007, FF, read: DATA=0034. Sequence 60 then 33: STATUS=8'hB0.
- Assert RESET low mid-erase: BUSY=0 and STATUS=80 at once, all blocks locked. With macro defined, WE and OE low together sets ERR_FLAGS=4'b0001.

Source files
------------

// File: rtl/nor_flash_responder.sv
`default_nettype none
// ============================================================================
//  Module   : nor_flash_responder
//  Purpose  : Device-side model of a parallel NOR flash (Intel/StrataFlash
//             command set). Decodes bus write strobes into commands, keeps
//             64 block lock bits, a status register, ID space, erase/program
//             busy timing and a small modeled word window inside one block.
//  Ports    : CLK       - clock, all bus pins sampled on its rising edge
//             RESET     - asynchronous active-low reset
//             CE/WE/OE  - active-low chip, write and output enables
//             ADDR      - 24-bit word address (block = ADDR[21:16])
//             DATA      - bidirectional data, high-Z unless reading
//             BUSY      - erase or program in progress
//             STATUS    - live status register
//             ERR_FLAGS - sticky bus-timing violation flags
//  Options  : define NOR_RESP_TIMING_CHECK_EN to build the bus-timing
//             checker; otherwise ERR_FLAGS is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module nor_flash_responder #(
  parameter int          ACCESS_CYCLES = 3,
  parameter int          ERASE_CYCLES  = 1000,
  parameter int          PROG_CYCLES   = 20,
  parameter int          ARRAY_AW      = 8,
  parameter logic [5:0]  WIN_BLOCK     = 6'h3F,
  parameter logic [15:0] DEVICE_ID     = 16'h0018
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  input  logic        WE,
  input  logic        OE,
  input  logic [23:0] ADDR,
  inout  wire  [15:0] DATA,
  output logic        BUSY,
  output logic [7:0]  STATUS,
  output logic [3:0]  ERR_FLAGS
);

  localparam int BUSY_MAX = (ERASE_CYCLES > PROG_CYCLES) ? ERASE_CYCLES : PROG_CYCLES;
  localparam int CNT_W    = $clog2(BUSY_MAX + 1);
  localparam int RD_W     = $clog2(ACCESS_CYCLES + 2);

  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_WAIT_LOCK2     = 3'd1,
    S_WAIT_ERASE2    = 3'd2,
    S_WAIT_PROG_DATA = 3'd3,
    S_ERASING        = 3'd4,
    S_PROGRAMMING    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    M_READ_ARRAY  = 2'd0,
    M_READ_ID     = 2'd1,
    M_READ_STATUS = 2'd2
  } mode_e;

  state_e              state_q;
  mode_e               mode_q;
  logic [63:0]         lock_q;
  logic [7:0]          status_q;
  logic                busy_q;
  logic [CNT_W-1:0]    busy_cnt_q;
  logic [ARRAY_AW-1:0] wipe_idx_q;
  logic                erase_win_q;

  logic                low_q;
  logic [5:0]          blk_lat_q;
  logic [ARRAY_AW-1:0] off_lat_q;
  logic [15:0]         data_lat_q;

  logic [RD_W-1:0]     rd_cnt_q;
  logic [15:0]         dout_q;
  logic [15:0]         rd_data_d;

  logic [15:0]         mem_q [2**ARRAY_AW];

  logic                strobe;
  logic [7:0]          cmd;
  logic                lat_locked;
  logic                lat_in_win;
  logic                wipe_we;
  logic                prog_we;
  logic                drive_en;
  logic                unused_addr;

  // ADDR[23:22] and the in-block bits above the window are don't-care.
  assign unused_addr = ^ADDR;

  // A strobe is the cycle after a CE/WE-low cycle in which either goes high;
  // address and data come from the last low cycle.
  assign strobe     = low_q && (WE || CE);
  assign cmd        = data_lat_q[7:0];
  assign lat_locked = lock_q[blk_lat_q];
  assign lat_in_win = (blk_lat_q == WIN_BLOCK);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      low_q      <= 1'b0;
      blk_lat_q  <= '0;
      off_lat_q  <= '0;
      data_lat_q <= '0;
    end else begin
      low_q <= !CE && !WE;
      if (!CE && !WE) begin
        blk_lat_q  <= ADDR[21:16];
        off_lat_q  <= ADDR[ARRAY_AW-1:0];
        data_lat_q <= DATA;
      end
    end
  end

  // Command state machine with registered mode, lock, status and busy.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      mode_q      <= M_READ_ARRAY;
      lock_q      <= '1;
      status_q    <= 8'h80;
      busy_q      <= 1'b0;
      busy_cnt_q  <= '0;
      wipe_idx_q  <= '0;
      erase_win_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (strobe) begin
            case (cmd)
              8'hFF: mode_q <= M_READ_ARRAY;
              8'h90: mode_q <= M_READ_ID;
              8'h70: mode_q <= M_READ_STATUS;
              8'h50: begin
                status_q[5:3] <= 3'b000;
                status_q[1]   <= 1'b0;
              end
              8'h60:        state_q <= S_WAIT_LOCK2;
              8'h20:        state_q <= S_WAIT_ERASE2;
              8'h40, 8'h10: state_q <= S_WAIT_PROG_DATA;
              default: ;
            endcase
          end
        end

        S_WAIT_LOCK2: begin
          if (strobe) begin
            state_q <= S_IDLE;
            mode_q  <= M_READ_STATUS;
            if (cmd == 8'hD0) begin
              lock_q[blk_lat_q] <= 1'b0;
            end else if (cmd == 8'h01) begin
              lock_q[blk_lat_q] <= 1'b1;
            end else begin
              status_q[5:4] <= 2'b11;
            end
          end
        end

        S_WAIT_ERASE2: begin
          if (strobe) begin
            mode_q <= M_READ_STATUS;
            if (cmd != 8'hD0) begin
              status_q[5:4] <= 2'b11;
              state_q       <= S_IDLE;
            end else if (lat_locked) begin
              status_q[5] <= 1'b1;
              status_q[1] <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              state_q     <= S_ERASING;
              busy_q      <= 1'b1;
              status_q[7] <= 1'b0;
              busy_cnt_q  <= '0;
              wipe_idx_q  <= '0;
              erase_win_q <= lat_in_win;
            end
          end
        end

        S_WAIT_PROG_DATA: begin
          if (strobe) begin
            mode_q <= M_READ_STATUS;
            if (lat_locked) begin
              status_q[4] <= 1'b1;
              status_q[1] <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              state_q     <= S_PROGRAMMING;
              busy_q      <= 1'b1;
              status_q[7] <= 1'b0;
              busy_cnt_q  <= '0;
            end
          end
        end

        S_ERASING: begin
          // Wipe index parks on the last word; the erase time covers the window.
          if (wipe_idx_q != {ARRAY_AW{1'b1}}) begin
            wipe_idx_q <= wipe_idx_q + 1'b1;
          end
          if (busy_cnt_q >= CNT_W'(ERASE_CYCLES - 1)) begin
            busy_q      <= 1'b0;
            status_q[7] <= 1'b1;
            erase_win_q <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            busy_cnt_q <= busy_cnt_q + 1'b1;
          end
        end

        S_PROGRAMMING: begin
          if (busy_cnt_q >= CNT_W'(PROG_CYCLES - 1)) begin
            busy_q      <= 1'b0;
            status_q[7] <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            busy_cnt_q <= busy_cnt_q + 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Modeled window: not reset, so an aborted erase leaves partial wipes.
  assign wipe_we = (state_q == S_ERASING) && erase_win_q;
  assign prog_we = (state_q == S_WAIT_PROG_DATA) && strobe && !lat_locked && lat_in_win;

  always_ff @(posedge CLK) begin
    if (wipe_we) begin
      mem_q[wipe_idx_q] <= 16'hFFFF;
    end else if (prog_we) begin
      mem_q[off_lat_q] <= mem_q[off_lat_q] & data_lat_q;
    end
  end

  // Read data selection; status wins while busy.
  always_comb begin
    rd_data_d = 16'hFFFF;
    if (busy_q) begin
      rd_data_d = {8'h00, status_q};
    end else begin
      case (mode_q)
        M_READ_ARRAY: begin
          if (ADDR[21:16] == WIN_BLOCK) rd_data_d = mem_q[ADDR[ARRAY_AW-1:0]];
        end
        M_READ_ID: begin
          case (ADDR[7:0])
            8'h00:   rd_data_d = 16'h0089;
            8'h01:   rd_data_d = DEVICE_ID;
            8'h02:   rd_data_d = {15'b0, lock_q[ADDR[21:16]]};
            default: rd_data_d = 16'h0000;
          endcase
        end
        M_READ_STATUS: rd_data_d = {8'h00, status_q};
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_cnt_q <= '0;
      dout_q   <= 16'hFFFF;
    end else begin
      dout_q <= rd_data_d;
      if (CE || OE) begin
        rd_cnt_q <= '0;
      end else if (rd_cnt_q < RD_W'(ACCESS_CYCLES)) begin
        rd_cnt_q <= rd_cnt_q + 1'b1;
      end
    end
  end

  assign drive_en = !CE && !OE && WE && (rd_cnt_q >= RD_W'(ACCESS_CYCLES));
  assign DATA     = drive_en ? dout_q : 16'hzzzz;

  assign BUSY   = busy_q;
  assign STATUS = status_q;

`ifdef NOR_RESP_TIMING_CHECK_EN
  logic [3:0] err_q;
  logic [1:0] we_lo_cnt_q;
  logic       we_prev_q;
  logic       ce_prev_q;
  logic       oe_prev_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      err_q       <= 4'h0;
      we_lo_cnt_q <= 2'd0;
      we_prev_q   <= 1'b1;
      ce_prev_q   <= 1'b1;
      oe_prev_q   <= 1'b1;
    end else begin
      we_prev_q <= WE;
      ce_prev_q <= CE;
      oe_prev_q <= OE;
      // Number of consecutive sampled WE-low cycles, saturating at 2.
      if (!WE) begin
        if (we_lo_cnt_q != 2'd2) we_lo_cnt_q <= we_lo_cnt_q + 2'd1;
      end else begin
        we_lo_cnt_q <= 2'd0;
      end
      if (!CE && !WE && !OE)                      err_q[0] <= 1'b1;
      if (!we_prev_q && WE && (we_lo_cnt_q < 2'd2)) err_q[1] <= 1'b1;
      if (strobe && busy_q)                       err_q[2] <= 1'b1;
      if (!ce_prev_q && !oe_prev_q && CE && (rd_cnt_q < RD_W'(ACCESS_CYCLES)))
        err_q[3] <= 1'b1;
    end
  end

  assign ERR_FLAGS = err_q;
`else
  assign ERR_FLAGS = 4'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nor_flash_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nor_flash_responder
//  Purpose  : Self-checking bench for nor_flash_responder. Bus-level tasks
//             issue whole flash operations and update a word/lock/status
//             model of the device; reads and status are compared against it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nor_flash_responder;

  localparam int          ACCESS_CYCLES = 3;
  localparam int          ERASE_CYCLES  = 1000;
  localparam int          PROG_CYCLES   = 20;
  localparam int          ARRAY_AW      = 8;
  localparam logic [5:0]  WIN_BLOCK     = 6'h3F;
  localparam logic [15:0] DEVICE_ID     = 16'h0018;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce, we, oe;
  logic [23:0] addr;
  wire  [15:0] data_bus;
  logic        busy;
  logic [7:0]  status;
  logic [3:0]  err_flags;
  logic        tb_drv;
  logic [15:0] tb_data;

  assign data_bus = tb_drv ? tb_data : 16'hzzzz;

  always #5 clk = ~clk;

  nor_flash_responder #(
    .ACCESS_CYCLES(ACCESS_CYCLES), .ERASE_CYCLES(ERASE_CYCLES), .PROG_CYCLES(PROG_CYCLES),
    .ARRAY_AW(ARRAY_AW), .WIN_BLOCK(WIN_BLOCK), .DEVICE_ID(DEVICE_ID)
  ) dut (
    .CLK(clk), .RESET(rst_n), .CE(ce), .WE(we), .OE(oe), .ADDR(addr), .DATA(data_bus),
    .BUSY(busy), .STATUS(status), .ERR_FLAGS(err_flags)
  );

  int n_vec = 0;
  int n_mis = 0;

  // Device model: mode 0 = array, 1 = ID, 2 = status.
  bit          model_lock [64];
  logic [15:0] model_mem  [256];
  logic [7:0]  model_status;
  int          model_mode;

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) model_lock[i] = 1'b1;
    model_status = 8'h80;
    model_mode   = 0;
  endfunction

  function automatic logic [15:0] model_read(input logic [23:0] a);
    logic [15:0] r;
    r = 16'h0000;
    if (model_mode == 0) begin
      r = (a[21:16] == WIN_BLOCK) ? model_mem[a[7:0]] : 16'hFFFF;
    end else if (model_mode == 1) begin
      if (a[7:0] == 8'd0)      r = 16'h0089;
      else if (a[7:0] == 8'd1) r = DEVICE_ID;
      else if (a[7:0] == 8'd2) r = {15'b0, model_lock[a[21:16]]};
    end else begin
      r = {8'h00, model_status};
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two low cycles, then release; command executes on the release edge.
  task automatic bus_write(input logic [23:0] a, input logic [15:0] d);
    addr = a; tb_data = d; tb_drv = 1'b1; ce = 1'b0; we = 1'b0;
    tick(); tick();
    we = 1'b1; ce = 1'b1;
    tick();
    tb_drv = 1'b0;
  endtask

  task automatic bus_read(input logic [23:0] a, output logic [15:0] d);
    addr = a; ce = 1'b0; oe = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    d = data_bus;
    tick();
    ce = 1'b1; oe = 1'b1;
    tick();
  endtask

  // Counts busy cycles; n = -1 when BUSY outlives the limit.
  task automatic wait_idle(input int limit, output int n, output int st7_hi);
    bit done;
    n = 0; st7_hi = 0; done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      if (busy) begin
        n++;
        if (status[7]) st7_hi++;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) n = -1;
    tick();
  endtask

  task automatic op_cmd(input logic [23:0] a, input logic [7:0] c);
    bus_write(a, {8'h00, c});
    case (c)
      8'hFF: model_mode = 0;
      8'h90: model_mode = 1;
      8'h70: model_mode = 2;
      8'h50: model_status = model_status & 8'hC5;
      default: ;
    endcase
  endtask

  task automatic op_lock(input logic [5:0] blk, input bit set);
    bus_write({2'b00, blk, 16'h0000}, 16'h0060);
    bus_write({2'b00, blk, 16'h0000}, set ? 16'h0001 : 16'h00D0);
    model_lock[blk] = set;
    model_mode = 2;
  endtask

  task automatic op_program(input logic [23:0] a, input logic [15:0] d, output int n);
    int st;
    bus_write(a, 16'h0040);
    bus_write(a, d);
    wait_idle(PROG_CYCLES + 10, n, st);
    model_mode = 2;
    if (model_lock[a[21:16]]) model_status = model_status | 8'h12;
    else if (a[21:16] == WIN_BLOCK) model_mem[a[7:0]] = model_mem[a[7:0]] & d;
  endtask

  task automatic op_erase(input logic [5:0] blk, output int n, output int st7_hi);
    bus_write({2'b00, blk, 16'h0000}, 16'h0020);
    bus_write({2'b00, blk, 16'h0000}, 16'h00D0);
    wait_idle(ERASE_CYCLES + 20, n, st7_hi);
    model_mode = 2;
    if (model_lock[blk]) model_status = model_status | 8'h22;
    else if (blk == WIN_BLOCK) for (int i = 0; i < 256; i++) model_mem[i] = 16'hFFFF;
  endtask

  task automatic op_badseq(input logic [5:0] blk);
    logic [7:0] v;
    v = 8'($urandom_range(2, 8'hCF));
    bus_write({2'b00, blk, 16'h0000}, 16'h0060);
    bus_write({2'b00, blk, 16'h0000}, {8'h00, v});
    model_status = model_status | 8'h30;
    op_cmd({2'b00, blk, 16'h0000}, 8'h70);
  endtask

  // ------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1; we = 1'b1; oe = 1'b1; addr = '0; tb_drv = 1'b0; tb_data = '0;
    repeat (3) tick();
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (status !== 8'h80) begin n_mis++; $display("FAIL reset_status: got %h expected 80", status); end
    n_vec++; if (err_flags !== 4'h0) begin n_mis++; $display("FAIL reset_err: got %h expected 0", err_flags); end
    tick();
    rst_n = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic test_id();
    logic [15:0] got;
    op_cmd(24'h3F0000, 8'h90);
    bus_read(24'h3F0002, got);
    n_vec++; if (got !== 16'h0001) begin n_mis++; $display("FAIL id_lock: got %h expected 0001", got); end
    bus_read(24'h3F0000, got);
    n_vec++; if (got !== 16'h0089) begin n_mis++; $display("FAIL id_mfr: got %h expected 0089", got); end
    bus_read(24'h3F0001, got);
    n_vec++; if (got !== DEVICE_ID) begin n_mis++; $display("FAIL id_dev: got %h expected %h", got, DEVICE_ID); end
    bus_read(24'h3F0003, got);
    n_vec++; if (got !== 16'h0000) begin n_mis++; $display("FAIL id_other: got %h expected 0000", got); end
  endtask

  task automatic test_unlock();
    logic [15:0] got;
    op_lock(WIN_BLOCK, 1'b0);
    op_cmd(24'h3F0000, 8'h90);
    bus_read(24'h3F0002, got);
    n_vec++; if (got !== 16'h0000) begin n_mis++; $display("FAIL unlock_id: got %h expected 0000", got); end
    op_cmd(24'h3F0000, 8'h70);
    bus_read(24'h3F0000, got);
    n_vec++; if (got !== 16'h0080) begin n_mis++; $display("FAIL unlock_status: got %h expected 0080", got); end
  endtask

  task automatic test_erase_locked();
    int n, st;
    op_erase(6'h02, n, st);
    n_vec++; if (n !== 0) begin n_mis++; $display("FAIL erase_locked_busy: got %0d busy cycles expected 0", n); end
    n_vec++; if (status !== 8'hA2) begin n_mis++; $display("FAIL erase_locked_status: got %h expected A2", status); end
    op_cmd(24'h020000, 8'h50);
    n_vec++; if (status !== 8'h80) begin n_mis++; $display("FAIL clear_status: got %h expected 80", status); end
  endtask

  task automatic test_erase_program();
    int n, st;
    logic [15:0] got;
    op_program(24'h3F0005, 16'h1234, n);
    n_vec++; if (n !== PROG_CYCLES) begin n_mis++; $display("FAIL prog_busy: got %0d expected %0d", n, PROG_CYCLES); end
    op_erase(WIN_BLOCK, n, st);
    n_vec++; if (n !== ERASE_CYCLES) begin n_mis++; $display("FAIL erase_busy: got %0d expected %0d", n, ERASE_CYCLES); end
    n_vec++; if (st !== 0) begin n_mis++; $display("FAIL erase_st7: got %0d ready cycles while busy expected 0", st); end
    n_vec++; if (status !== 8'h80) begin n_mis++; $display("FAIL erase_done_status: got %h expected 80", status); end
    op_cmd(24'h3F0000, 8'hFF);
    bus_read(24'h3F0005, got);
    n_vec++; if (got !== 16'hFFFF) begin n_mis++; $display("FAIL erase_word: got %h expected FFFF", got); end
    bus_read(24'h3F00FF, got);
    n_vec++; if (got !== 16'hFFFF) begin n_mis++; $display("FAIL erase_last: got %h expected FFFF", got); end
  endtask

  task automatic test_program_and();
    int n;
    logic [15:0] got;
    op_program(24'h3F0007, 16'h1234, n);
    op_program(24'h3F0007, 16'h00FF, n);
    op_cmd(24'h3F0000, 8'hFF);
    bus_read(24'h3F0007, got);
    n_vec++; if (got !== 16'h0034) begin n_mis++; $display("FAIL prog_and: got %h expected 0034", got); end
    op_badseq(WIN_BLOCK);
    n_vec++; if (status !== 8'hB0) begin n_mis++; $display("FAIL bad_seq: got %h expected B0", status); end
    op_cmd(24'h3F0000, 8'h50);
  endtask

  task automatic test_back_to_back();
    int n, st;
    logic [15:0] got;
    bus_write(24'h3F0010, 16'h0040);
    bus_write(24'h3F0010, 16'h0F0F);
    bus_write(24'h3F0000, 16'h00FF);   // must be ignored while busy
    wait_idle(PROG_CYCLES + 10, n, st);
    model_mode = 2;
    model_mem[8'h10] = model_mem[8'h10] & 16'h0F0F;
    n_vec++; if (n !== PROG_CYCLES - 3) begin n_mis++; $display("FAIL b2b_busy: got %0d expected %0d", n, PROG_CYCLES - 3); end
    bus_read(24'h3F0010, got);
    n_vec++; if (got !== model_read(24'h3F0010)) begin n_mis++; $display("FAIL b2b_ignored: got %h expected %h", got, model_read(24'h3F0010)); end
`ifdef NOR_RESP_TIMING_CHECK_EN
    n_vec++; if (err_flags[2] !== 1'b1) begin n_mis++; $display("FAIL err_busy_strobe: got %b expected 1", err_flags[2]); end
`endif
    op_cmd(24'h3F0000, 8'hFF);
    bus_read(24'h3F0010, got);
    n_vec++; if (got !== 16'h0F0F) begin n_mis++; $display("FAIL b2b_word: got %h expected 0F0F", got); end
  endtask

  task automatic test_random();
    int n, st, exp_n;
    logic [15:0] got, d;
    logic [23:0] a;
    logic [5:0]  blk;
    for (int it = 0; it < 60; it++) begin
      blk = ($urandom_range(0, 1) == 0) ? WIN_BLOCK : 6'($urandom_range(0, 63));
      a   = {2'($urandom_range(0, 3)), blk, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      case ($urandom_range(0, 7))
        0: begin
          d = 16'($urandom);
          exp_n = model_lock[blk] ? 0 : PROG_CYCLES;
          op_program(a, d, n);
          n_vec++; if (n !== exp_n) begin n_mis++; $display("FAIL rnd_prog_busy: got %0d expected %0d", n, exp_n); end
          n_vec++; if (status !== model_status) begin n_mis++; $display("FAIL rnd_prog_status: got %h expected %h", status, model_status); end
        end
        1: begin
          op_lock(blk, 1'($urandom_range(0, 1)));
          n_vec++; if (status !== model_status) begin n_mis++; $display("FAIL rnd_lock_status: got %h expected %h", status, model_status); end
        end
        2: begin
          op_cmd(a, 8'hFF);
          bus_read(a, got);
          n_vec++; if (got !== model_read(a)) begin n_mis++; $display("FAIL rnd_array @%h: got %h expected %h", a, got, model_read(a)); end
        end
        3: begin
          op_cmd(a, 8'h90);
          a[7:0] = 8'($urandom_range(0, 3));
          bus_read(a, got);
          n_vec++; if (got !== model_read(a)) begin n_mis++; $display("FAIL rnd_id @%h: got %h expected %h", a, got, model_read(a)); end
        end
        4: begin
          op_cmd(a, 8'h70);
          bus_read(a, got);
          n_vec++; if (got !== model_read(a)) begin n_mis++; $display("FAIL rnd_status_read: got %h expected %h", got, model_read(a)); end
        end
        5: begin
          op_cmd(a, 8'h50);
          n_vec++; if (status !== model_status) begin n_mis++; $display("FAIL rnd_clear: got %h expected %h", status, model_status); end
        end
        6: begin
          op_badseq(blk);
          n_vec++; if (status !== model_status) begin n_mis++; $display("FAIL rnd_badseq: got %h expected %h", status, model_status); end
        end
        default: begin
          exp_n = model_lock[blk] ? 0 : ERASE_CYCLES;
          op_erase(blk, n, st);
          n_vec++; if (n !== exp_n) begin n_mis++; $display("FAIL rnd_erase_busy: got %0d expected %0d", n, exp_n); end
          n_vec++; if (status !== model_status) begin n_mis++; $display("FAIL rnd_erase_status: got %h expected %h", status, model_status); end
        end
      endcase
    end
  endtask

  task automatic test_reset_mid_erase();
    int n;
    logic [15:0] got, exp255;
    op_lock(WIN_BLOCK, 1'b0);
    op_program(24'h3F0000, 16'h0000, n);
    op_program(24'h3F00FF, 16'h5A5A, n);
    exp255 = model_mem[255];
    bus_write(24'h3F0000, 16'h0020);
    bus_write(24'h3F0000, 16'h00D0);
    repeat (50) tick();
    n_vec++; if (busy !== 1'b1) begin n_mis++; $display("FAIL mid_erase_busy: got %b expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_mis++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_vec++; if (status !== 8'h80) begin n_mis++; $display("FAIL abort_status: got %h expected 80", status); end
    tick();
    rst_n = 1'b1;
    tick();
    model_reset();
    op_cmd(24'h3F0000, 8'h90);
    bus_read(24'h3F0002, got);
    n_vec++; if (got !== 16'h0001) begin n_mis++; $display("FAIL abort_lock_win: got %h expected 0001", got); end
    bus_read(24'h150002, got);
    n_vec++; if (got !== 16'h0001) begin n_mis++; $display("FAIL abort_lock_15: got %h expected 0001", got); end
    op_cmd(24'h3F0000, 8'hFF);
    bus_read(24'h3F0000, got);
    n_vec++; if (got !== 16'hFFFF) begin n_mis++; $display("FAIL abort_wiped: got %h expected FFFF", got); end
    bus_read(24'h3F00FF, got);
    n_vec++; if (got !== exp255) begin n_mis++; $display("FAIL abort_kept: got %h expected %h", got, exp255); end
  endtask

  task automatic test_timing_flags();
    logic [3:0] exp;
`ifdef NOR_RESP_TIMING_CHECK_EN
    exp = 4'b0001;
`else
    exp = 4'b0000;
`endif
    addr = 24'h000000; ce = 1'b0; we = 1'b0; oe = 1'b0;
    repeat (3) tick();
    ce = 1'b1; we = 1'b1; oe = 1'b1;
    tick(); tick();
    n_vec++; if (err_flags !== exp) begin n_mis++; $display("FAIL timing_flags: got %b expected %b", err_flags, exp); end
  endtask

  initial begin
    test_reset();
    test_id();
    test_unlock();
    test_erase_locked();
    test_erase_program();
    test_program_and();
    test_back_to_back();
    test_random();
    test_reset_mid_erase();
    test_timing_flags();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
